// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: one outstanding data-memory access with lane steering.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning.
module ysyx_25020047_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_read,
   input  logic        in_write,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [2:0]  in_funct3,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic        out_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT_CYCLES);

   state_t            state_q, state_d;
   logic [29:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [3:0]        wmask_q, wmask_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [1:0]  off_in;
   logic [31:0] st_data;
   logic [3:0]  st_mask;
   logic        bad_op;
   logic        trap;
   logic [31:0] shifted;
   logic [31:0] ld_data;

   // Halfword/word offsets are forced to natural alignment here.
   always_comb begin
      off_in  = in_addr[1:0];
      st_data = in_wdata;
      st_mask = 4'b1111;
      case (in_funct3[1:0])
         2'b00: begin
            st_data = {4{in_wdata[7:0]}};
            st_mask = 4'b0001 << in_addr[1:0];
         end
         2'b01: begin
            off_in  = {in_addr[1], 1'b0};
            st_data = {2{in_wdata[15:0]}};
            st_mask = 4'b0011 << {in_addr[1], 1'b0};
         end
         default: off_in = 2'b00;
      endcase
   end

   assign bad_op = (in_read == in_write) || (in_funct3 == 3'b011) ||
                   (in_funct3[2:1] == 2'b11) || (in_write && in_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                 ((in_funct3[1:0] == 2'b10) && (|in_addr[1:0]));
`else
   assign trap = 1'b0;
`endif

   assign shifted = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  ld_data = {24'h0, shifted[7:0]};
         3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  ld_data = {16'h0, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      wmask_d = wmask_q;
      f3_d    = f3_q;
      off_d   = off_q;
      we_d    = we_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               addr_d  = in_addr[31:2];
               f3_d    = in_funct3;
               off_d   = off_in;
               we_d    = in_write;
               wdata_d = st_data;
               wmask_d = in_write ? st_mask : 4'b0000;
               rdata_d = 32'h0;
               err_d   = 1'b0;
               if (bad_op || trap) begin
                  state_d = RESP;
                  err_d   = 1'b1;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            if (mem_rsp_valid) begin
               state_d = RESP;
               rdata_d = we_q ? 32'h0 : ld_data;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO)) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = 32'h0;
            end
         end
         RESP: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wmask_q <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wmask_q <= wmask_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         we_q    <= we_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign mem_req_valid = (state_q == REQ);
   assign mem_we        = we_q;
   assign mem_addr      = {addr_q, 2'b00};
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;
   assign out_valid     = (state_q == RESP);
   assign out_rdata     = rdata_q;
   assign out_err       = err_q;

endmodule
